// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode constants, ALU/PC-control encodings,
// the decoded-bundle struct and the funct3 -> ALU-op helper.
package riscv_pkg;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluXor  = 4'd2,
    AluOr   = 4'd3,
    AluAnd  = 4'd4,
    AluSll  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    PcSeq    = 2'b00,
    PcBranch = 2'b01,
    PcJal    = 2'b10,
    PcJalr   = 2'b11
  } pcfunc_e;

  // XLEN-dependent fields (immediate, pcoffset, pc) travel beside this struct.
  typedef struct packed {
    pcfunc_e     pcfunc;
    logic [2:0]  brcond;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        we;
    logic [4:0]  rd;
    alu_op_e     aluop;
    logic        selopr2;
    logic        selopr1pc;
    logic        memread;
    logic        memwrite;
    logic [2:0]  memsize;
    logic        illegal;
  } dec_bundle_t;

  // alt = instruction bit 30; only meaningful for funct3 000 (sub) and 101 (sra).
  function automatic alu_op_e alu_from_funct3(logic [2:0] funct3, logic alt);
    alu_op_e op;
    unique case (funct3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I instruction decoder.
//   i_instruction : raw 32-bit instruction
//   o_bundle      : decoded control fields (illegal encodings zero all but .illegal)
//   o_immediate   : sign-extended immediate (zero-extended shamt for shifts)
//   o_pcoffset    : low PCOFFW bits of the B/J immediate, else 0
module decode_comb
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PCOFFW = 22
) (
  input  logic [31:0]       i_instruction,
  output dec_bundle_t       o_bundle,
  output logic [XLEN-1:0]   o_immediate,
  output logic [PCOFFW-1:0] o_pcoffset
);

  logic [6:0]      w_opcode;
  logic [6:0]      w_funct7;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_sh;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  logic            w_rd_write;
  logic            w_use_rs1;
  logic            w_use_rs2;

  assign w_opcode = i_instruction[6:0];
  assign w_rd     = i_instruction[11:7];
  assign w_funct3 = i_instruction[14:12];
  assign w_rs1    = i_instruction[19:15];
  assign w_rs2    = i_instruction[24:20];
  assign w_funct7 = i_instruction[31:25];

  assign w_imm_i  = XLEN'($signed(i_instruction[31:20]));
  assign w_imm_s  = XLEN'($signed({i_instruction[31:25], i_instruction[11:7]}));
  assign w_imm_b  = XLEN'($signed({i_instruction[31], i_instruction[7], i_instruction[30:25],
                                   i_instruction[11:8], 1'b0}));
  assign w_imm_u  = XLEN'($signed({i_instruction[31:12], 12'b0}));
  assign w_imm_j  = XLEN'($signed({i_instruction[31], i_instruction[19:12], i_instruction[20],
                                   i_instruction[30:21], 1'b0}));
  assign w_imm_sh = XLEN'(i_instruction[24:20]);

  always_comb begin
    o_bundle   = '0;
    w_imm      = '0;
    w_illegal  = 1'b0;
    w_rd_write = 1'b0;
    w_use_rs1  = 1'b0;
    w_use_rs2  = 1'b0;

    // Every valid opcode ends in 2'b11, so anything else falls to default.
    case (w_opcode)
      OpcOp: begin
        w_illegal = !((w_funct7 == 7'b0000000) ||
                      ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) ||
                                                    (w_funct3 == 3'b101))));
        o_bundle.aluop = alu_from_funct3(w_funct3, w_funct7[5]);
        w_rd_write = 1'b1;
        w_use_rs1  = 1'b1;
        w_use_rs2  = 1'b1;
      end
      OpcOpImm: begin
        if (w_funct3 == 3'b001) begin
          w_illegal = (w_funct7 != 7'b0000000);
          w_imm     = w_imm_sh;
        end else if (w_funct3 == 3'b101) begin
          w_illegal = !((w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000));
          w_imm     = w_imm_sh;
        end else begin
          w_imm     = w_imm_i;
        end
        // Bit 30 is part of the immediate for addi, so only srai may use it.
        o_bundle.aluop   = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
        o_bundle.selopr2 = 1'b1;
        w_rd_write = 1'b1;
        w_use_rs1  = 1'b1;
      end
      OpcLui: begin
        w_imm            = w_imm_u;
        o_bundle.selopr2 = 1'b1;
        w_rd_write       = 1'b1;
      end
      OpcAuipc: begin
        w_imm              = w_imm_u;
        o_bundle.selopr2   = 1'b1;
        o_bundle.selopr1pc = 1'b1;
        w_rd_write         = 1'b1;
      end
      OpcJal: begin
        w_imm              = w_imm_j;
        o_bundle.pcfunc    = PcJal;
        o_bundle.selopr1pc = 1'b1;
        w_rd_write         = 1'b1;
      end
      OpcJalr: begin
        w_imm              = w_imm_i;
        o_bundle.pcfunc    = PcJalr;
        o_bundle.selopr1pc = 1'b1;
        w_rd_write         = 1'b1;
        w_use_rs1          = 1'b1;
      end
      OpcBranch: begin
        w_illegal       = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
        w_imm           = w_imm_b;
        o_bundle.pcfunc = PcBranch;
        o_bundle.brcond = w_funct3;
        o_bundle.aluop  = AluSub;
        w_use_rs1       = 1'b1;
        w_use_rs2       = 1'b1;
      end
      OpcLoad: begin
        w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
        w_imm            = w_imm_i;
        o_bundle.memread = 1'b1;
        o_bundle.memsize = w_funct3;
        o_bundle.selopr2 = 1'b1;
        w_rd_write       = 1'b1;
        w_use_rs1        = 1'b1;
      end
      OpcStore: begin
        w_illegal         = (w_funct3 > 3'b010);
        w_imm             = w_imm_s;
        o_bundle.memwrite = 1'b1;
        o_bundle.memsize  = w_funct3;
        o_bundle.selopr2  = 1'b1;
        w_use_rs1         = 1'b1;
        w_use_rs2         = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase

    // Unused sources read as x0 so the hazard compare never matches them.
    o_bundle.rs1 = w_use_rs1 ? w_rs1 : 5'd0;
    o_bundle.rs2 = w_use_rs2 ? w_rs2 : 5'd0;
    o_bundle.we  = w_rd_write && (w_rd != 5'd0);
    o_bundle.rd  = o_bundle.we ? w_rd : 5'd0;

    // Illegal: a side-effect-free bundle that EX can trap on.
    if (w_illegal) begin
      o_bundle         = '0;
      o_bundle.illegal = 1'b1;
      w_imm            = '0;
    end
  end

  assign o_immediate = w_imm;
  assign o_pcoffset  = ((o_bundle.pcfunc == PcBranch) || (o_bundle.pcfunc == PcJal)) ?
                       w_imm[PCOFFW-1:0] : '0;

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage between fetch and execute.
//   clock/resetn           : rising-edge clock, async active-low reset
//   flush                  : drop held bundle and incoming instruction
//   in_valid/in_ready      : fetch-side handshake; in_instruction, in_pc
//   out_valid/out_ready    : execute-side handshake; out_pc + decoded fields
//   stall_count            : saturating count of load-use bubbles
module decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PCOFFW  = 22,
  parameter int unsigned STALLCW = 16
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instruction,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [1:0]         pcfunc,
  output logic [PCOFFW-1:0]  pcoffset,
  output logic [2:0]         brcond,
  output logic [4:0]         readselect1,
  output logic [4:0]         readselect2,
  output logic               writeenable,
  output logic [4:0]         writeselect,
  output logic [3:0]         aluoper,
  output logic               selopr2,
  output logic               selopr1pc,
  output logic [XLEN-1:0]    immediate,
  output logic               memread,
  output logic               memwrite,
  output logic [2:0]         memsize,
  output logic               illegal,
  output logic [STALLCW-1:0] stall_count
);

  dec_bundle_t         w_dec;
  logic [XLEN-1:0]     w_imm;
  logic [PCOFFW-1:0]   w_pcoff;
  logic                w_hazard;
  logic                w_in_ready;
  logic                w_accept;

  dec_bundle_t         r_bundle;
  logic [XLEN-1:0]     r_imm;
  logic [PCOFFW-1:0]   r_pcoff;
  logic [XLEN-1:0]     r_pc;
  logic                r_valid;
  logic [STALLCW-1:0]  r_stall;

  decode_comb #(
    .XLEN   (XLEN),
    .PCOFFW (PCOFFW)
  ) u_decode_comb (
    .i_instruction (in_instruction),
    .o_bundle      (w_dec),
    .o_immediate   (w_imm),
    .o_pcoffset    (w_pcoff)
  );

  // Load-use: the load leaving this cycle cannot forward to the next instruction.
  // Unused sources are already x0, and rd==0 never matches.
  assign w_hazard = r_valid && r_bundle.memread && out_ready && (r_bundle.rd != 5'd0) &&
                    ((r_bundle.rd == w_dec.rs1) || (r_bundle.rd == w_dec.rs2));

  // A flush ignores the hazard: the instruction is accepted and thrown away.
  assign w_in_ready = (flush || !w_hazard) && (!r_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_bundle <= '0;
      r_imm    <= '0;
      r_pcoff  <= '0;
      r_pc     <= '0;
      r_valid  <= 1'b0;
      r_stall  <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid  <= 1'b1;
        r_bundle <= w_dec;
        r_imm    <= w_imm;
        r_pcoff  <= w_pcoff;
        r_pc     <= in_pc;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end

      if (w_hazard && !flush && (r_stall != '1)) begin
        r_stall <= r_stall + STALLCW'(1);
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign pcfunc      = r_bundle.pcfunc;
  assign pcoffset    = r_pcoff;
  assign brcond      = r_bundle.brcond;
  assign readselect1 = r_bundle.rs1;
  assign readselect2 = r_bundle.rs2;
  assign writeenable = r_bundle.we;
  assign writeselect = r_bundle.rd;
  assign aluoper     = r_bundle.aluop;
  assign selopr2     = r_bundle.selopr2;
  assign selopr1pc   = r_bundle.selopr1pc;
  assign immediate   = r_imm;
  assign memread     = r_bundle.memread;
  assign memwrite    = r_bundle.memwrite;
  assign memsize     = r_bundle.memsize;
  assign illegal     = r_bundle.illegal;
  assign stall_count = r_stall;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases pinned with literal values,
// then a randomized stream compared every cycle against a behavioural model.
module tb_decode_stage;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PCOFFW  = 22;
  localparam int unsigned STALLCW = 4;
  localparam int unsigned SMAX    = (1 << STALLCW) - 1;

  logic               clock = 1'b0;
  logic               resetn = 1'b0;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [31:0]        in_instruction = '0;
  logic [XLEN-1:0]    in_pc = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [XLEN-1:0]    out_pc;
  logic [1:0]         pcfunc;
  logic [PCOFFW-1:0]  pcoffset;
  logic [2:0]         brcond;
  logic [4:0]         readselect1;
  logic [4:0]         readselect2;
  logic               writeenable;
  logic [4:0]         writeselect;
  logic [3:0]         aluoper;
  logic               selopr2;
  logic               selopr1pc;
  logic [XLEN-1:0]    immediate;
  logic               memread;
  logic               memwrite;
  logic [2:0]         memsize;
  logic               illegal;
  logic [STALLCW-1:0] stall_count;

  decode_stage #(
    .XLEN    (XLEN),
    .PCOFFW  (PCOFFW),
    .STALLCW (STALLCW)
  ) dut (
    .clock          (clock),
    .resetn         (resetn),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instruction (in_instruction),
    .in_pc          (in_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .pcfunc         (pcfunc),
    .pcoffset       (pcoffset),
    .brcond         (brcond),
    .readselect1    (readselect1),
    .readselect2    (readselect2),
    .writeenable    (writeenable),
    .writeselect    (writeselect),
    .aluoper        (aluoper),
    .selopr2        (selopr2),
    .selopr1pc      (selopr1pc),
    .immediate      (immediate),
    .memread        (memread),
    .memwrite       (memwrite),
    .memsize        (memsize),
    .illegal        (illegal),
    .stall_count    (stall_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    bit        ill;
    bit [1:0]  pcf;
    bit [2:0]  brc;
    bit [4:0]  rs1;
    bit [4:0]  rs2;
    bit [4:0]  rd;
    bit        we;
    bit [3:0]  alu;
    bit        s2;
    bit        s1pc;
    bit        mr;
    bit        mw;
    bit [2:0]  msz;
    bit [31:0] imm;
    bit [21:0] pcoff;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        m_b     = '0;
  bit          m_valid = 1'b0;
  bit [31:0]   m_pc    = '0;
  int unsigned m_stall = 0;
  bit          last_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU code by funct3 (add,sll,slt,sltu,xor,srl,or,and); alt turns add->sub, srl->sra.
  function automatic bit [3:0] alu_of(bit [2:0] f3, bit alt);
    bit [3:0] tab [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};
    if (alt && f3 == 3'd0) return 4'd1;
    if (alt && f3 == 3'd5) return 4'd7;
    return tab[f3];
  endfunction

  function automatic exp_t ref_decode(bit [31:0] ins);
    exp_t     e     = '0;
    bit [6:0] op    = ins[6:0];
    bit [2:0] f3    = ins[14:12];
    bit [6:0] f7    = ins[31:25];
    bit       legal = 1'b1;
    bit       wr    = 1'b0;
    bit       u1    = 1'b0;
    bit       u2    = 1'b0;
    bit [31:0] si, ss, sb, su, sj;
    si = 32'($signed(ins) >>> 20);
    ss = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
    sb = (32'($signed(ins) >>> 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) |
         (32'(ins[11:8]) << 1);
    su = ins & 32'hFFFF_F000;
    sj = (32'($signed(ins) >>> 31) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) |
         (32'(ins[30:21]) << 1);
    case (op)
      7'h33: begin
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        e.alu = alu_of(f3, f7 == 7'h20);
        wr = 1; u1 = 1; u2 = 1;
      end
      7'h13: begin
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
        e.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : si;
        e.alu = alu_of(f3, f3 == 3'd5 && f7 == 7'h20);
        e.s2 = 1; wr = 1; u1 = 1;
      end
      7'h37: begin e.imm = su; e.s2 = 1; wr = 1; end
      7'h17: begin e.imm = su; e.s2 = 1; e.s1pc = 1; wr = 1; end
      7'h6F: begin e.imm = sj; e.pcf = 2'b10; e.s1pc = 1; wr = 1; end
      7'h67: begin e.imm = si; e.pcf = 2'b11; e.s1pc = 1; wr = 1; u1 = 1; end
      7'h63: begin
        legal = !(f3 == 3'd2 || f3 == 3'd3);
        e.imm = sb; e.pcf = 2'b01; e.brc = f3; e.alu = 4'd1; u1 = 1; u2 = 1;
      end
      7'h03: begin
        legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        e.imm = si; e.mr = 1; e.msz = f3; e.s2 = 1; wr = 1; u1 = 1;
      end
      7'h23: begin
        legal = (f3 <= 3'd2);
        e.imm = ss; e.mw = 1; e.msz = f3; e.s2 = 1; u1 = 1; u2 = 1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e     = '0;
      e.ill = 1'b1;
      return e;
    end
    e.rs1   = u1 ? ins[19:15] : 5'd0;
    e.rs2   = u2 ? ins[24:20] : 5'd0;
    e.we    = wr && (ins[11:7] != 5'd0);
    e.rd    = e.we ? ins[11:7] : 5'd0;
    e.pcoff = (e.pcf == 2'b01 || e.pcf == 2'b10) ? e.imm[21:0] : 22'd0;
    return e;
  endfunction

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("stall_count", 32'(stall_count), m_stall);
    if (m_valid) begin
      chk("illegal", 32'(illegal), 32'(m_b.ill));
      chk("writeenable", 32'(writeenable), 32'(m_b.we));
      chk("writeselect", 32'(writeselect), 32'(m_b.rd));
      chk("memread", 32'(memread), 32'(m_b.mr));
      chk("memwrite", 32'(memwrite), 32'(m_b.mw));
      chk("pcfunc", 32'(pcfunc), 32'(m_b.pcf));
      chk("out_pc", out_pc, m_pc);
      if (!m_b.ill) begin
        chk("brcond", 32'(brcond), 32'(m_b.brc));
        chk("readselect1", 32'(readselect1), 32'(m_b.rs1));
        chk("readselect2", 32'(readselect2), 32'(m_b.rs2));
        chk("aluoper", 32'(aluoper), 32'(m_b.alu));
        chk("selopr2", 32'(selopr2), 32'(m_b.s2));
        chk("selopr1pc", 32'(selopr1pc), 32'(m_b.s1pc));
        chk("immediate", immediate, m_b.imm);
        chk("memsize", 32'(memsize), 32'(m_b.msz));
        chk("pcoffset", 32'(pcoffset), 32'(m_b.pcoff));
      end
    end
  endtask

  // One cycle: called between negedge and posedge, returns at the next negedge.
  task automatic step(input bit v, input bit [31:0] ins, input bit [31:0] pc,
                      input bit ordy, input bit fl);
    exp_t d;
    bit   hz;
    bit   rdy;
    in_valid = v; in_instruction = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    d   = ref_decode(ins);
    hz  = m_valid && m_b.mr && ordy && (m_b.rd != 5'd0) && (m_b.rd == d.rs1 || m_b.rd == d.rs2);
    rdy = (fl || !hz) && (!m_valid || ordy);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    last_rdy = in_ready;
    @(posedge clock);
    if (hz && !fl && m_stall < SMAX) m_stall++;
    if (fl) m_valid = 1'b0;
    else if (v && rdy) begin m_valid = 1'b1; m_b = d; m_pc = pc; end
    else if (ordy) m_valid = 1'b0;
    @(negedge clock);
    check_outputs();
  endtask

  function automatic bit [31:0] rand_instr();
    bit [31:0] r   = $urandom;
    bit [4:0]  rd  = 5'($urandom_range(0, 3));
    bit [4:0]  rs1 = 5'($urandom_range(0, 3));
    bit [4:0]  rs2 = 5'($urandom_range(0, 3));
    bit [2:0]  f3  = r[14:12];
    bit [6:0]  f7  = r[31:25];
    if (r[0]) f7 = r[1] ? 7'h20 : 7'h00;
    case ($urandom_range(0, 10))
      0, 1:    return {r[31:20], rs1, (r[2] ? 3'b010 : f3), rd, 7'b0000011};
      2:       return {f7, rs2, rs1, f3, rd, 7'b0110011};
      3:       return {f7, r[24:20], rs1, f3, rd, 7'b0010011};
      4:       return {r[31:12], rd, 7'b0110111};
      5:       return {r[31:12], rd, 7'b0010111};
      6:       return {r[31:12], rd, 7'b1101111};
      7:       return {r[31:20], rs1, f3, rd, 7'b1100111};
      8:       return {f7, rs2, rs1, f3, r[11:7], 7'b1100011};
      9:       return {f7, rs2, rs1, f3, r[11:7], 7'b0100011};
      default: return $urandom;
    endcase
  endfunction

  localparam bit [31:0] ADDI_X1 = 32'hFFB0_0093;  // addi x1,x0,-5
  localparam bit [31:0] ADD_X2  = 32'h0010_8133;  // add  x2,x1,x1
  localparam bit [31:0] LW_X5   = 32'h0000_A283;  // lw   x5,0(x1)
  localparam bit [31:0] ADD_X6  = 32'h0002_8333;  // add  x6,x5,x0
  localparam bit [31:0] BEQ_M8  = 32'hFE20_8CE3;  // beq  x1,x2,-8
  localparam bit [31:0] BAD_SUB = 32'h4220_81B3;  // sub with funct7=0100001

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);
    chk("rst_immediate", immediate, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    resetn = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    step(1, ADDI_X1, 32'h100, 1, 0);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_imm", immediate, 32'hFFFF_FFFB);
    chk("addi_alu", 32'(aluoper), 32'd0);
    chk("addi_selopr2", 32'(selopr2), 32'd1);
    chk("addi_rd", 32'(writeselect), 32'd1);
    step(1, ADD_X2, 32'h104, 1, 0);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_alu", 32'(aluoper), 32'd0);
    chk("add_rs1", 32'(readselect1), 32'd1);
    chk("add_rs2", 32'(readselect2), 32'd1);

    step(1, LW_X5, 32'h108, 1, 0);
    chk("lw_memread", 32'(memread), 32'd1);
    step(1, ADD_X6, 32'h10C, 1, 0);
    chk("hz_in_ready", 32'(last_rdy), 32'd0);
    chk("hz_bubble", 32'(out_valid), 32'd0);
    chk("hz_stall", 32'(stall_count), 32'd1);
    step(1, ADD_X6, 32'h10C, 1, 0);
    chk("hz_add_valid", 32'(out_valid), 32'd1);
    chk("hz_add_rd", 32'(writeselect), 32'd6);

    step(1, BEQ_M8, 32'h110, 1, 0);
    chk("beq_pcfunc", 32'(pcfunc), 32'd1);
    chk("beq_pcoffset", 32'(pcoffset), 32'h003F_FFF8);
    chk("beq_brcond", 32'(brcond), 32'd0);
    chk("beq_alu", 32'(aluoper), 32'd1);
    chk("beq_we", 32'(writeenable), 32'd0);

    for (int i = 0; i < 3; i++) begin
      step(1, ADDI_X1, 32'h114, 0, 0);
      chk("hold_in_ready", 32'(last_rdy), 32'd0);
      chk("hold_pc", out_pc, 32'h110);
    end

    step(1, ADD_X2, 32'h118, 0, 1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    step(0, ADD_X2, 32'h11C, 1, 0);
    chk("flush_none", 32'(out_valid), 32'd0);

    step(1, 32'h0000_0000, 32'h120, 1, 0);
    chk("zero_illegal", 32'(illegal), 32'd1);
    chk("zero_we", 32'(writeenable), 32'd0);
    step(1, BAD_SUB, 32'h124, 1, 0);
    chk("badsub_illegal", 32'(illegal), 32'd1);
    chk("badsub_we", 32'(writeenable), 32'd0);
    chk("badsub_valid", 32'(out_valid), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 8, rand_instr(), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end

    for (int i = 0; i < 17; i++) begin
      step(1, LW_X5, 32'h200, 1, 0);
      step(1, ADD_X6, 32'h204, 1, 0);
      step(1, ADD_X6, 32'h204, 1, 0);
    end
    chk("stall_saturated", 32'(stall_count), SMAX);

    step(1, ADDI_X1, 32'h300, 1, 0);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_stall", 32'(stall_count), 32'd0);
    chk("midrst_imm", immediate, 32'd0);
    chk("midrst_rd", 32'(writeselect), 32'd0);
    m_valid = 1'b0; m_b = '0; m_pc = '0; m_stall = 0;
    @(negedge clock);
    resetn = 1'b1;
    step(1, ADD_X2, 32'h304, 1, 0);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_pc", out_pc, 32'h304);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
